// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/load-store arbiter in front of a single-port synchronous RAM with a small I/O window
// Load/store wins contention except when fetch has been starved STARVE_MAX cycles; responses return one cycle after grant.
module mem_arbiter #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 16'hFF00,
  parameter int                    STARVE_MAX = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_gnt,
  output logic                  ls_valid,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  input  logic [DATA_WIDTH-1:0] io_in,
  output logic [DATA_WIDTH-1:0] io_out
);

  localparam int CW = ($clog2(STARVE_MAX + 1) < 2) ? 2 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]         STARVE_LIM = CW'(STARVE_MAX);
  localparam logic [ADDR_WIDTH-1:0] IO_SW      = IO_BASE + ADDR_WIDTH'(1);

  logic [CW-1:0]         starve;
  logic [DATA_WIDTH-1:0] io_out_q;
  logic                  rsp_if;
  logic                  rsp_ls;
  logic                  rsp_store;
  logic                  rsp_io;
  logic [DATA_WIDTH-1:0] rsp_io_data;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [DATA_WIDTH-1:0] io_rd;
  logic                  if_is_io;
  logic                  ls_is_io;

  assign if_is_io = (if_addr >= IO_BASE);
  assign ls_is_io = (ls_addr >= IO_BASE);

  // Grants are suppressed during reset so nothing is accepted or written.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!reset) begin
      if_gnt = if_req & (~ls_req | (starve == STARVE_LIM));
      ls_gnt = ls_req & ~if_gnt;
    end
  end

  assign mem_address = ls_gnt ? ls_addr : if_addr;
  assign mem_data    = ls_wdata;
  assign mem_wren    = ls_gnt & ls_we & ~ls_is_io;

  always_comb begin
    io_rd = '0;
    if (ls_addr == IO_BASE)
      io_rd = io_out_q;
    else if (ls_addr == IO_SW)
      io_rd = io_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve      <= '0;
      io_out_q    <= '0;
      rsp_if      <= 1'b0;
      rsp_ls      <= 1'b0;
      rsp_store   <= 1'b0;
      rsp_io      <= 1'b0;
      rsp_io_data <= '0;
    end else begin
      if (if_req && !if_gnt) begin
        if (starve != STARVE_LIM)
          starve <= starve + CW'(1);
      end else begin
        starve <= '0;
      end
      if (ls_gnt && ls_we && (ls_addr == IO_BASE))
        io_out_q <= ls_wdata;
      rsp_if      <= if_gnt;
      rsp_ls      <= ls_gnt;
      rsp_store   <= ls_gnt & ls_we;
      rsp_io      <= if_gnt ? if_is_io : ls_is_io;
      // Fetches from I/O space read as zero, so only load/store captures I/O data.
      rsp_io_data <= ls_gnt ? io_rd : '0;
    end
  end

  always_comb begin
    rsp_rdata = mem_q;
    if (rsp_store)
      rsp_rdata = '0;
    else if (rsp_io)
      rsp_rdata = rsp_io_data;
  end

  assign if_valid = rsp_if;
  assign ls_valid = rsp_ls;
  assign if_rdata = rsp_if ? rsp_rdata : '0;
  assign ls_rdata = rsp_ls ? rsp_rdata : '0;
  assign io_out   = io_out_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter with a RAM model and a per-cycle reference model
module tb_mem_arbiter;

  localparam logic [15:0] IO_BASE    = 16'hFF00;
  localparam int          STARVE_MAX = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_valid;
  logic [15:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_valid;
  logic [15:0] ls_addr, ls_wdata, ls_rdata;
  logic [15:0] mem_address, mem_data, mem_q;
  logic        mem_wren;
  logic [15:0] io_in, io_out;

  logic        pre_we;
  logic [15:0] pre_addr, pre_data;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
    .io_in(io_in), .io_out(io_out)
  );

  always #5 clock = ~clock;

  // Synchronous RAM: registered address, write lands at the edge, q follows the registered address.
  logic [15:0] ram [0:65535];
  logic [15:0] ram_addr_q;
  always @(posedge clock) begin
    if (pre_we)
      ram[pre_addr] <= pre_data;
    else if (mem_wren)
      ram[mem_address] <= mem_data;
    ram_addr_q <= mem_address;
  end
  assign mem_q = ram[ram_addr_q];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: shadow memory, LED register, starvation age, one pending response.
  logic [15:0] shadow [0:65535];
  logic [15:0] m_io_out = '0;
  int          m_starve = 0;
  logic        p_if = 1'b0, p_ls = 1'b0;
  logic [15:0] p_data = '0;

  initial begin : model_compare
    logic e_if_gnt, e_ls_gnt, e_wren;
    forever begin
      @(negedge clock);
      if (reset) begin
        m_io_out = '0;
        m_starve = 0;
        p_if     = 1'b0;
        p_ls     = 1'b0;
        p_data   = '0;
      end
      chk("m_if_valid", if_valid, p_if);
      chk("m_ls_valid", ls_valid, p_ls);
      chk("m_if_rdata", if_rdata, p_if ? p_data : 16'h0);
      chk("m_ls_rdata", ls_rdata, p_ls ? p_data : 16'h0);
      e_if_gnt = !reset && if_req && (!ls_req || m_starve == STARVE_MAX);
      e_ls_gnt = !reset && ls_req && !e_if_gnt;
      e_wren   = e_ls_gnt && ls_we && (ls_addr < IO_BASE);
      chk("m_if_gnt", if_gnt, e_if_gnt);
      chk("m_ls_gnt", ls_gnt, e_ls_gnt);
      chk("m_mem_wren", mem_wren, e_wren);
      chk("m_mem_address", mem_address, e_ls_gnt ? ls_addr : if_addr);
      chk("m_mem_data", mem_data, ls_wdata);
      chk("m_io_out", io_out, m_io_out);
      if (!reset) begin
        p_if   = e_if_gnt;
        p_ls   = e_ls_gnt;
        p_data = '0;
        if (e_if_gnt)
          p_data = (if_addr >= IO_BASE) ? 16'h0 : shadow[if_addr];
        else if (e_ls_gnt && !ls_we) begin
          if (ls_addr < IO_BASE)          p_data = shadow[ls_addr];
          else if (ls_addr == IO_BASE)    p_data = m_io_out;
          else if (ls_addr == IO_BASE + 1) p_data = io_in;
        end
        if (e_ls_gnt && ls_we) begin
          if (ls_addr < IO_BASE)       shadow[ls_addr] = ls_wdata;
          else if (ls_addr == IO_BASE) m_io_out = ls_wdata;
        end
        if (if_req && !e_if_gnt)
          m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
        else
          m_starve = 0;
      end
      if (pre_we)
        shadow[pre_addr] = pre_data;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [15:0] ia,
                       input logic lr, input logic lw, input logic [15:0] la, input logic [15:0] ld);
    if_req = ir; if_addr = ia;
    ls_req = lr; ls_we = lw; ls_addr = la; ls_wdata = ld;
  endtask

  logic [7:0] gseq;

  initial begin
    reset = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0; io_in = 16'h0;
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
    tick();
    pre_we = 1'b1; pre_addr = 16'h0010; pre_data = 16'hABCD; tick();
    pre_addr = 16'h0011; pre_data = 16'h1111; tick();
    pre_we = 1'b0; tick();
    @(negedge clock);
    chk("reset_if_gnt", if_gnt, 1'b0);
    chk("reset_wren", mem_wren, 1'b0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_ls_valid", ls_valid, 1'b0);
    chk("rst_io_out", io_out, 16'h0);
    tick();

    // Fetch 0x0010
    drive(1, 16'h0010, 0, 0, 16'h0, 16'h0);
    @(negedge clock);
    chk("fetch_gnt", if_gnt, 1'b1);
    chk("fetch_wren", mem_wren, 1'b0);
    tick();
    drive(0, 16'h0010, 0, 0, 16'h0, 16'h0);
    @(negedge clock);
    chk("fetch_valid", if_valid, 1'b1);
    chk("fetch_rdata", if_rdata, 16'hABCD);
    tick();

    // Store then load same address
    drive(0, 16'h0, 1, 1, 16'h0020, 16'h1234);
    @(negedge clock);
    chk("st_wren", mem_wren, 1'b1);
    tick();
    drive(0, 16'h0, 1, 0, 16'h0020, 16'h0);
    @(negedge clock);
    chk("ld_wren", mem_wren, 1'b0);
    chk("st_ack_valid", ls_valid, 1'b1);
    chk("st_ack_rdata", ls_rdata, 16'h0);
    tick();
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
    @(negedge clock);
    chk("ld_valid", ls_valid, 1'b1);
    chk("ld_rdata", ls_rdata, 16'h1234);
    tick();

    // Continuous contention: fetch granted every fourth cycle
    drive(1, 16'h0010, 1, 0, 16'h0011, 16'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      gseq[i] = if_gnt;
      tick();
    end
    chk("grant_seq", gseq, 8'b1000_1000);
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
    tick();

    // I/O window
    drive(0, 16'h0, 1, 1, 16'hFF00, 16'h00F5);
    @(negedge clock);
    chk("io_st_wren", mem_wren, 1'b0);
    tick();
    drive(0, 16'h0, 1, 0, 16'hFF00, 16'h0);
    @(negedge clock);
    chk("io_out_set", io_out, 16'h00F5);
    tick();
    io_in = 16'h5A5A;
    drive(0, 16'h0, 1, 0, 16'hFF01, 16'h0);
    @(negedge clock);
    chk("io_ld_led", ls_rdata, 16'h00F5);
    tick();
    drive(1, 16'hFF01, 0, 0, 16'h0, 16'h0);
    @(negedge clock);
    chk("io_ld_sw", ls_rdata, 16'h5A5A);
    tick();
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
    @(negedge clock);
    chk("io_fetch_valid", if_valid, 1'b1);
    chk("io_fetch_rdata", if_rdata, 16'h0);
    tick();

    // Reset during an in-flight load response
    drive(0, 16'h0, 1, 0, 16'h0020, 16'h0);
    @(negedge clock);
    chk("pre_rst_ls_gnt", ls_gnt, 1'b1);
    tick();
    reset = 1'b1;
    drive(1, 16'h0010, 0, 0, 16'h0, 16'h0);
    @(negedge clock);
    chk("rst_flush_valid", ls_valid, 1'b0);
    chk("rst_flush_io", io_out, 16'h0);
    chk("rst_no_gnt", if_gnt, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_gnt", if_gnt, 1'b1);
    chk("post_rst_ls_valid", ls_valid, 1'b0);
    tick();
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
    @(negedge clock);
    chk("post_rst_valid", if_valid, 1'b1);
    chk("post_rst_rdata", if_rdata, 16'hABCD);
    tick();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
